alu_seq: RTL and testbench
==========================

# alu_seq

Registered, handshaked successor to the team's combinational 4-op ALU. It is parametrised in width and extends the op set to eight: add, sub, or, and, xor, two shifts, and an optional multi-cycle multiply. Operands enter through a valid/ready input port. Result and flags leave through a valid/ready output port and are held until consumed. The block sits between the datapath register file/operand latches and the result writeback/display stage.

## Interface
- `M`, 8: operand/result width in bits (≥4, power of two).
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `in_valid` in 1: operands and opcode are valid this cycle.
- `in_ready` out 1: block can accept an operation this cycle.
- `A` in M: operand A.
- `B` in M: operand B; for shifts, `B[$clog2(M)-1:0]` is the shift amount.
- `OpCode` in 3: operation select.
- `out_valid` out 1: `Result`/`Flags` are valid.
- `out_ready` in 1: consumer accepts the result this cycle.
- `Result` out M: registered result.
- `Flags` out 5: registered `{N, Z, C, V, P}`.

## Operation
- Opcodes:
  - 000 SUB: A−B.
  - 001 ADD: A+B.
  - 010 OR.
  - 011 AND.
  - 100 XOR.
  - 101 SHL: logical shift left by `B[$clog2(M)-1:0]`.
  - 110 SHR: logical shift right by the same amount.
  - 111 MUL: low M bits of the unsigned product.
- Common flags:
  - N = `Result[M-1]`.
  - Z = (`Result`==0).
  - P = ^`Result` (1 = odd parity).
- ADD: C = carry out of bit M−1. V = signed overflow (both operands same sign, result sign differs).
- SUB: computed at M+1 bits. C = bit M, i.e. borrow, 1 iff A<B unsigned. V = operand signs differ and result sign differs from A.
- Logic ops: C=0, V=0.
- Shifts: C = last bit shifted out (0 if amount=0). V=0.
- MUL: computed as an M-step shift-add over an internal 2M-bit accumulator. C = V = (upper M bits of product ≠ 0).
- State machine:
  - IDLE: `in_ready`=1. On `in_valid`: a non-MUL op is computed and registered, go to DONE; MUL loads the multiplier, go to BUSY.
  - BUSY: `in_ready`=0. A step counter counts 0..M−1. After step M−1, register the result and flags, go to DONE.
  - DONE: `out_valid`=1, outputs held stable. On `out_ready`, go to IDLE.
- No pass-through: `in_ready`=1 only in IDLE. Operands are sampled only at acceptance; A/B/OpCode changes after acceptance are ignored.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State → IDLE, counter → 0.
  - `Result`=0, `Flags`=5'b00000, `out_valid`=0, `in_ready`=1 the cycle after.
  - Reset mid-MUL or mid-DONE aborts the operation and discards the pending result.
- Non-MUL: accepted at edge k → `out_valid`=1 after edge k (latency 1). Earliest next acceptance is the edge after the result is consumed.
- MUL: accepted at edge k → `out_valid`=1 after edge k+M.
- Backpressure: `out_valid` stays 1 with `Result`/`Flags` unchanged for any number of cycles while `out_ready`=0.
- `in_valid` while `in_ready`=0 is ignored; nothing is queued.
- `out_ready` while `out_valid`=0 has no effect.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - MUL is implemented as above.
  - BUSY state and step counter exist.
- `ALU_SEQ_MUL_EN` undefined:
  - No multiplier, counter, or BUSY state.
  - Opcode 111 completes with latency 1: `Result`=0, `Flags`=5'b01000.

## Structure
- Package `alu_pkg` holds:
  - Opcode enum `alu_op_e` (3-bit).
  - Flag bit-index constants `FLAG_N`=4, `FLAG_Z`=3, `FLAG_C`=2, `FLAG_V`=1, `FLAG_P`=0.
  - State enum `alu_state_e` {IDLE, BUSY, DONE}.
- Sub-module `alu_seq_mul` (instantiated only under `ALU_SEQ_MUL_EN`): start/done interface, M-cycle shift-add, 2M-bit product out.
- Top contains the FSM, the combinational single-cycle op unit, and the flag logic.

## Test plan
All cases at M=8.
- ADD 8'h7F+8'h01 → `Result`=8'h80, `Flags`=5'b10011, `out_valid` one cycle after acceptance.
- SUB 8'h00−8'h01 → `Result`=8'hFF, `Flags`=5'b10100. SUB 8'h05−8'h05 → 8'h00, `Flags`=5'b01000.
- SHL 8'h81 by 1 → 8'h02, `Flags`=5'b00101. SHR 8'h81 by 0 → 8'h81, C=0.
- MUL 8'h10×8'h10 → `Result`=8'h00, `Flags`=5'b01110 after 8 cycles; `in_ready`=0 throughout BUSY. MUL 8'h03×8'h05 → 8'h0F, `Flags`=5'b00000.
- Backpressure: `out_ready`=0 for 3 cycles after ADD → outputs stable, `in_ready`=0, new `in_valid` ignored. Then `out_ready`=1 → IDLE next cycle.
- `rst_n`=0 at cycle 4 of a MUL → next cycle IDLE, `out_valid`=0, `Result`=0, `Flags`=0. Without `ALU_SEQ_MUL_EN`, opcode 111 → 8'h00, `Flags`=5'b01000, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, flag bit positions and FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 4;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_P = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the operand source and the ALU.
interface alu_seq_if #(parameter int M = 8);

    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] A;
    logic [M-1:0] B;
    logic [2:0]   OpCode;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] Result;
    logic [4:0]   Flags;

    modport master (
        output in_valid, A, B, OpCode, out_ready,
        input  in_ready, out_valid, Result, Flags
    );

    modport slave (
        input  in_valid, A, B, OpCode, out_ready,
        output in_ready, out_valid, Result, Flags
    );

endinterface

// File: rtl/alu_seq_mul.sv
// M-step shift-add unsigned multiplier; prod is valid combinationally when done=1.
module alu_seq_mul #(parameter int M = 8) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [M-1:0]   a,
    input  logic [M-1:0]   b,
    output logic           done,
    output logic [2*M-1:0] prod
);
    localparam int CW = $clog2(M);

    logic           busy_q, busy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*M-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_step;
    logic [M-1:0]   mplier_q, mplier_d;

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{M{1'b0}}, a};
            mplier_d = b;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(M-1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // The last step's sum is handed out directly so the top can register it on the same edge.
    assign done = busy_q && (cnt_q == CW'(M-1));
    assign prod = acc_step;

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked 8-op ALU. MUL is built only when ALU_SEQ_MUL_EN is defined;
// otherwise opcode 111 completes in one cycle with a zero result.
module alu_seq #(parameter int M = 8) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    import alu_pkg::*;

    localparam int SW = $clog2(M);

    alu_state_e   state_q, state_d;
    logic [M-1:0] result_q, result_d;
    logic [4:0]   flags_q, flags_d;

    alu_op_e      op;
    logic [SW-1:0] amt;
    logic [M:0]   sum_w, diff_w, shl_w, shr_w;
    logic [M-1:0] alu_res;
    logic         alu_c, alu_v;

    function automatic logic [4:0] mk_flags(input logic [M-1:0] r, input logic c, input logic v);
        logic [4:0] f;
        f[FLAG_N] = r[M-1];
        f[FLAG_Z] = (r == '0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        f[FLAG_P] = ^r;
        return f;
    endfunction

    assign op     = alu_op_e'(bus.OpCode);
    assign amt    = bus.B[SW-1:0];
    assign sum_w  = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff_w = {1'b0, bus.A} - {1'b0, bus.B};
    // One spare bit on the far side of each shift captures the last bit shifted out.
    assign shl_w  = {1'b0, bus.A} << amt;
    assign shr_w  = {bus.A, 1'b0} >> amt;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_SUB: begin
                alu_res = diff_w[M-1:0];
                alu_c   = diff_w[M];
                alu_v   = (bus.A[M-1] ^ bus.B[M-1]) & (diff_w[M-1] ^ bus.A[M-1]);
            end
            OP_ADD: begin
                alu_res = sum_w[M-1:0];
                alu_c   = sum_w[M];
                alu_v   = ~(bus.A[M-1] ^ bus.B[M-1]) & (sum_w[M-1] ^ bus.A[M-1]);
            end
            OP_OR:  alu_res = bus.A | bus.B;
            OP_AND: alu_res = bus.A & bus.B;
            OP_XOR: alu_res = bus.A ^ bus.B;
            OP_SHL: begin
                alu_res = shl_w[M-1:0];
                alu_c   = shl_w[M];
            end
            OP_SHR: begin
                alu_res = shr_w[M:1];
                alu_c   = shr_w[0];
            end
            default: ;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic           mul_start, mul_done, mul_hi_nz;
    logic [2*M-1:0] mul_prod;

    alu_seq_mul #(.M(M)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .a     (bus.A),
        .b     (bus.B),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    assign mul_hi_nz = |mul_prod[2*M-1:M];
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
        mul_start = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = BUSY;
                    end else begin
                        result_d = alu_res;
                        flags_d  = mk_flags(alu_res, alu_c, alu_v);
                        state_d  = DONE;
                    end
`else
                    result_d = alu_res;
                    flags_d  = mk_flags(alu_res, alu_c, alu_v);
                    state_d  = DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            BUSY: begin
                if (mul_done) begin
                    result_d = mul_prod[M-1:0];
                    flags_d  = mk_flags(mul_prod[M-1:0], mul_hi_nz, mul_hi_nz);
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.Result    = result_q;
    assign bus.Flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at M=8; MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

    typedef struct {
        logic [7:0] r;
        logic [4:0] f;
        int         extra;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb_q[$];

    alu_seq_if #(.M(8)) bus();

    alu_seq #(.M(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ia, ib, sa, sb, n, t, ts;
        logic c, v;
        ia = a; ib = b; sa = $signed(a); sb = $signed(b);
        n = b[2:0];
        c = 1'b0; v = 1'b0; t = 0; ts = 0;
        e.extra = 0;
        case (op)
            3'd0: begin t = ia - ib; e.r = t[7:0]; c = (ia < ib); ts = sa - sb; v = (ts > 127) || (ts < -128); end
            3'd1: begin t = ia + ib; e.r = t[7:0]; c = (t > 255); ts = sa + sb; v = (ts > 127) || (ts < -128); end
            3'd2: e.r = a | b;
            3'd3: e.r = a & b;
            3'd4: e.r = a ^ b;
            3'd5: begin t = ia << n; e.r = t[7:0]; if (n != 0) c = a[8-n]; end
            3'd6: begin e.r = a >> n; if (n != 0) c = a[n-1]; end
            default: begin
`ifdef ALU_SEQ_MUL_EN
                t = ia * ib; e.r = t[7:0]; c = (t > 255); v = c; e.extra = 8;
`else
                e.r = 8'h00;
`endif
            end
        endcase
        e.f = {e.r[7], (e.r == 8'h00), c, v, ^e.r};
        return e;
    endfunction

    // Issue one op, check acceptance/latency/result, hold for 'hold' cycles, then consume.
    task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic [4:0] ef, input int extra, input int hold);
        exp_t e;
        int lat;
        e.r = er; e.f = ef; e.extra = extra;
        chk("idle_rdy", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.OpCode = op; bus.A = a; bus.B = b;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.OpCode = 3'($urandom_range(0, 7));
        bus.A = 8'($urandom); bus.B = 8'($urandom);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            chk("busy_rdy", bus.in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        e = sb_q.pop_front();
        chk("latency", lat, e.extra);
        chk("result", bus.Result, e.r);
        chk("flags", bus.Flags, e.f);
        chk("done_rdy", bus.in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            bus.A = 8'($urandom); bus.B = 8'($urandom);
            @(posedge clk); #1;
            chk("hold_vld", bus.out_valid, 1);
            chk("hold_rdy", bus.in_ready, 0);
            chk("hold_res", bus.Result, e.r);
            chk("hold_flg", bus.Flags, e.f);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_rdy", bus.in_ready, 1);
        chk("post_vld", bus.out_valid, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy"}, bus.in_ready, 1);
        chk({tag, "_vld"}, bus.out_valid, 0);
        chk({tag, "_res"}, bus.Result, 0);
        chk({tag, "_flg"}, bus.Flags, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [2:0] rop;
        logic [7:0] ra, rb;
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.OpCode = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst_n = 1'b1;
        chk_reset_state("reset");

        // out_ready with nothing pending is a no-op
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("idle_vld", bus.out_valid, 0);

        do_op(3'b001, 8'h7F, 8'h01, 8'h80, 5'b10011, 0, 0);
        do_op(3'b000, 8'h00, 8'h01, 8'hFF, 5'b10100, 0, 0);
        do_op(3'b000, 8'h05, 8'h05, 8'h00, 5'b01000, 0, 0);
        do_op(3'b101, 8'h81, 8'h01, 8'h02, 5'b00101, 0, 0);
        do_op(3'b110, 8'h81, 8'h00, 8'h81, 5'b10000, 0, 0);
        do_op(3'b010, 8'hA0, 8'h05, 8'hA5, 5'b10000, 0, 0);
        do_op(3'b011, 8'hF0, 8'h3C, 8'h30, 5'b00000, 0, 0);
        do_op(3'b100, 8'hFF, 8'h0F, 8'hF0, 5'b10000, 0, 0);
`ifdef ALU_SEQ_MUL_EN
        do_op(3'b111, 8'h10, 8'h10, 8'h00, 5'b01110, 8, 0);
        do_op(3'b111, 8'h03, 8'h05, 8'h0F, 5'b00000, 8, 0);
`else
        do_op(3'b111, 8'h10, 8'h10, 8'h00, 5'b01000, 0, 0);
`endif
        // backpressure: held 3 cycles with new in_valid ignored
        do_op(3'b001, 8'h7F, 8'h01, 8'h80, 5'b10011, 0, 3);

        for (int k = 0; k < 40; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            e   = model(rop, ra, rb);
            do_op(rop, ra, rb, e.r, e.f, e.extra, int'($urandom_range(0, 2)));
        end

`ifdef ALU_SEQ_MUL_EN
        // reset in the 4th BUSY cycle aborts the multiply
        bus.in_valid = 1'b1; bus.OpCode = 3'b111; bus.A = 8'h03; bus.B = 8'h05;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_state("mulrst");
        repeat (10) @(posedge clk);
        #1;
        chk("mulrst_gone", bus.out_valid, 0);
`endif
        // reset while a result waits in DONE discards it
        bus.in_valid = 1'b1; bus.OpCode = 3'b001; bus.A = 8'h12; bus.B = 8'h34;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("dnrst_pre", bus.out_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_reset_state("dnrst");

        do_op(3'b001, 8'h01, 8'h01, 8'h02, 5'b00001, 0, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
